// File: rtl/multiexp_pkg.sv
// Shared types and width helpers for the multiexp scheduler.
package multiexp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DISPATCH,
      COLLECT,
      ADD_REQ,
      ADD_WAIT,
      OUTPUT
   } state_e;

   // Counter width for n states; never zero so a single-core build still has a legal vector.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Valid/ready stream bundle with framing and error side-band.
interface if_axi_stream #(
   parameter int DAT_BITS = 8,
   parameter int CTL_BITS = 8
);
   logic                val;
   logic                rdy;
   logic                sop;
   logic                eop;
   logic                err;
   logic [DAT_BITS-1:0] dat;
   logic [CTL_BITS-1:0] ctl;

   modport source (output val, sop, eop, err, dat, ctl, input rdy);
   modport sink   (input val, sop, eop, err, dat, ctl, output rdy);
endinterface

// File: rtl/multiexp_sched.sv
// Splits a job of point/scalar pairs into per-core chunks, then folds the core
// partials through a shared external point adder into one output point.
module multiexp_sched
   import multiexp_pkg::*;
#(
   parameter int NUM_IN    = 16,
   parameter int NUM_CORES = 4,
   parameter int PNT_BITS  = 768,
   parameter int SCL_BITS  = 256,
   parameter int CTL_BITS  = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   if_axi_stream.sink                    i_pnt_scl_if,
   output logic [NUM_CORES-1:0]          o_core_val,
   input  logic [NUM_CORES-1:0]          i_core_rdy,
   output logic [PNT_BITS+SCL_BITS-1:0]  o_core_dat,
   output logic                          o_core_sop,
   output logic                          o_core_eop,
   input  logic [NUM_CORES-1:0]          i_res_val,
   input  logic [NUM_CORES*PNT_BITS-1:0] i_res_dat,
   output logic [NUM_CORES-1:0]          o_res_rdy,
   if_axi_stream.source                  o_add_if,
   if_axi_stream.sink                    i_add_if,
   if_axi_stream.source                  o_pnt_if
);

   localparam int M      = NUM_IN / NUM_CORES;
   localparam int SEL_W  = cnt_bits(NUM_CORES);
   localparam int BEAT_W = cnt_bits(M);
   localparam logic [SEL_W-1:0]  LAST_CORE = SEL_W'(NUM_CORES - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(M - 1);

   state_e                state_q,    state_d;
   logic [SEL_W-1:0]      core_sel_q, core_sel_d;
   logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic                  err_q,      err_d;
   logic [CTL_BITS-1:0]   job_ctl_q,  job_ctl_d;
   logic [PNT_BITS-1:0]   acc_q,      acc_d;
   logic [PNT_BITS-1:0]   opnd_q,     opnd_d;

   logic                  in_fire;
   logic                  last_beat;
   logic [PNT_BITS-1:0]   res_sel;

   // Framing side-band the scheduler does not consume.
   logic unused_ok;
   assign unused_ok = ^{i_pnt_scl_if.sop, i_pnt_scl_if.err,
                        i_add_if.sop, i_add_if.eop, i_add_if.err};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         core_sel_q <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
         job_ctl_q  <= '0;
      end else begin
         state_q    <= state_d;
         core_sel_q <= core_sel_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
         job_ctl_q  <= job_ctl_d;
      end
   end

   // NOTE: wide datapath registers carry no reset; every consumer is gated by the FSM state.
   always_ff @(posedge i_clk) begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
   end

   // NOTE: every variable gets a default first so no path leaves a latch behind.
   always_comb begin
      state_d    = state_q;
      core_sel_d = core_sel_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      job_ctl_d  = job_ctl_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      res_sel    = i_res_dat[int'(core_sel_q)*PNT_BITS +: PNT_BITS];
      in_fire    = (state_q == DISPATCH) && i_pnt_scl_if.val && i_core_rdy[core_sel_q];
      last_beat  = (core_sel_q == LAST_CORE) && (beat_cnt_q == LAST_BEAT);

      case (state_q)
         IDLE: begin
            if (i_pnt_scl_if.val) begin
               state_d    = DISPATCH;
               job_ctl_d  = i_pnt_scl_if.ctl;
               core_sel_d = '0;
               beat_cnt_d = '0;
            end
         end
         DISPATCH: begin
            if (in_fire) begin
               // Framing is count-driven; a misplaced or missing eop only flags the job.
               if (i_pnt_scl_if.eop != last_beat) err_d = 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  if (core_sel_q == LAST_CORE) begin
                     core_sel_d = '0;
                     state_d    = COLLECT;
                  end else begin
                     core_sel_d = core_sel_q + 1'b1;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         COLLECT: begin
            if (i_res_val[core_sel_q]) begin
               if (core_sel_q == '0) begin
                  acc_d = res_sel;
                  if (core_sel_q == LAST_CORE) state_d    = OUTPUT;
                  else                         core_sel_d = core_sel_q + 1'b1;
               end else begin
                  opnd_d  = res_sel;
                  state_d = ADD_REQ;
               end
            end
         end
         ADD_REQ: begin
            if (o_add_if.rdy) state_d = ADD_WAIT;
         end
         ADD_WAIT: begin
            if (i_add_if.val) begin
               acc_d = i_add_if.dat;
               if (i_add_if.ctl != CTL_BITS'(core_sel_q)) err_d = 1'b1;
               if (core_sel_q == LAST_CORE) begin
                  state_d = OUTPUT;
               end else begin
                  core_sel_d = core_sel_q + 1'b1;
                  state_d    = COLLECT;
               end
            end
         end
         OUTPUT: begin
            if (o_pnt_if.rdy) begin
               state_d    = IDLE;
               err_d      = 1'b0;
               core_sel_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_core_val       = '0;
      o_core_dat       = i_pnt_scl_if.dat;
      o_core_sop       = (beat_cnt_q == '0);
      o_core_eop       = (beat_cnt_q == LAST_BEAT);
      i_pnt_scl_if.rdy = 1'b0;
      o_res_rdy        = '0;
      o_add_if.val     = 1'b0;
      o_add_if.dat     = {opnd_q, acc_q};
      o_add_if.ctl     = CTL_BITS'(core_sel_q);
      o_add_if.sop     = 1'b1;
      o_add_if.eop     = 1'b1;
      o_add_if.err     = 1'b0;
      i_add_if.rdy     = 1'b0;
      o_pnt_if.val     = 1'b0;
      o_pnt_if.dat     = '0;
      o_pnt_if.ctl     = '0;
      o_pnt_if.sop     = 1'b0;
      o_pnt_if.eop     = 1'b0;
      o_pnt_if.err     = 1'b0;

      case (state_q)
         DISPATCH: begin
            o_core_val[core_sel_q] = i_pnt_scl_if.val;
            i_pnt_scl_if.rdy       = i_core_rdy[core_sel_q];
         end
         COLLECT:  o_res_rdy[core_sel_q] = 1'b1;
         ADD_REQ:  o_add_if.val = 1'b1;
         ADD_WAIT: i_add_if.rdy = 1'b1;
         OUTPUT: begin
            o_pnt_if.val = 1'b1;
            o_pnt_if.dat = acc_q;
            o_pnt_if.ctl = job_ctl_q;
            o_pnt_if.sop = 1'b1;
            o_pnt_if.eop = 1'b1;
            o_pnt_if.err = err_q;
         end
         default: ;
      endcase
   end

endmodule
